// File: rtl/frog_referee.sv
// frog_referee: game-rule stage between the frog/cars generators and the
// LED matrix driver. It detects collisions and goal arrival, keeps lives
// and score, freezes play during flash phases, and overrides the display
// arrays with full-matrix patterns while HIT/WIN/OVER are showing.
//
// Ports:
//   clk        game clock (divided, ~763 Hz)
//   reset      synchronous active-high reset
//   restart    one-cycle pulse, honoured only in OVER
//   red_in     car array,  row r = red_in[r],  column c = bit c
//   green_in   frog array, same indexing
//   red_out    red array forwarded to the driver
//   green_out  green array forwarded to the driver
//   frog_rst   registered one-cycle pulse sending the frog back to row 7
//   freeze     hold enable for frog/cars (state != PLAY)
//   lives      remaining lives
//   score      completed crossings, saturating
//   game_over  high while in OVER
//
// Optional feature: define FROG_REFEREE_BONUS_LIFE_EN to award a life on a
// winning crossing whose new score is a nonzero multiple of 4 (capped at
// LIVES).
module frog_referee #(
  parameter int LIVES        = 3,
  parameter int FLASH_CYCLES = 763,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic [7:0][7:0]    red_in,
  input  logic [7:0][7:0]    green_in,
  output logic [7:0][7:0]    red_out,
  output logic [7:0][7:0]    green_out,
  output logic               frog_rst,
  output logic               freeze,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int TIMER_W = (FLASH_CYCLES > 2) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FLASH_CYCLES - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    WIN  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t             state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [2:0]         lives_reg;
  logic [SCORE_W-1:0] score_reg;
  logic               frog_rst_reg;

  // Per-row overlap of cars and frog.
  logic [7:0] row_hit;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      assign row_hit[gi] = |(red_in[gi] & green_in[gi]);
    end
  endgenerate

  // While frog_rst is high the frog has not yet returned to its start row,
  // so whatever it overlaps this cycle is stale and must not score or hurt.
  logic collide;
  logic goal;
  assign collide = (|row_hit) & ~frog_rst_reg;
  assign goal    = (|green_in[0]) & ~frog_rst_reg;

  logic [SCORE_W-1:0] score_next;
  assign score_next = (score_reg == SCORE_MAX) ? score_reg
                                               : score_reg + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= PLAY;
      timer_reg    <= '0;
      lives_reg    <= LIVES_INIT;
      score_reg    <= '0;
      frog_rst_reg <= 1'b0;
    end else begin
      frog_rst_reg <= 1'b0;
      case (state_reg)
        PLAY: begin
          if (collide) begin
            lives_reg <= lives_reg - 3'd1;
            timer_reg <= '0;
            state_reg <= (lives_reg == 3'd1) ? OVER : HIT;
          end else if (goal) begin
            score_reg <= score_next;
            timer_reg <= '0;
            state_reg <= WIN;
`ifdef FROG_REFEREE_BONUS_LIFE_EN
            if ((score_next != '0) && (score_next[1:0] == 2'b00) &&
                (lives_reg < LIVES_INIT)) begin
              lives_reg <= lives_reg + 3'd1;
            end
`endif
          end
        end
        HIT, WIN: begin
          if (timer_reg == TIMER_LAST) begin
            timer_reg    <= '0;
            state_reg    <= PLAY;
            frog_rst_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        OVER: begin
          if (restart) begin
            lives_reg    <= LIVES_INIT;
            score_reg    <= '0;
            frog_rst_reg <= 1'b1;
            state_reg    <= PLAY;
          end
        end
        default: state_reg <= PLAY;
      endcase
    end
  end

  // Display substitution follows state with no added latency.
  always_comb begin
    red_out   = red_in;
    green_out = green_in;
    case (state_reg)
      HIT: begin
        red_out   = '1;
        green_out = '0;
      end
      WIN: begin
        red_out   = '0;
        green_out = '1;
      end
      OVER: begin
        red_out   = '1;
        green_out = '1;
      end
      default: begin
        red_out   = red_in;
        green_out = green_in;
      end
    endcase
  end

  assign freeze    = (state_reg != PLAY);
  assign game_over = (state_reg == OVER);
  assign frog_rst  = frog_rst_reg;
  assign lives     = lives_reg;
  assign score     = score_reg;

endmodule

// File: tb/tb_frog_referee.sv
// Directed bench for frog_referee with FLASH_CYCLES=4.
module tb_frog_referee;

  localparam int FC = 4;
  localparam logic [63:0] ONES = {64{1'b1}};
`ifdef FROG_REFEREE_BONUS_LIFE_EN
  localparam logic [2:0] BONUS_LIVES = 3'd3;
`else
  localparam logic [2:0] BONUS_LIVES = 3'd2;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            restart;
  logic [7:0][7:0] red_v;
  logic [7:0][7:0] green_v;
  logic [7:0][7:0] red_out;
  logic [7:0][7:0] green_out;
  logic            frog_rst;
  logic            freeze;
  logic [2:0]      lives;
  logic [3:0]      score;
  logic            game_over;

  int n_checks = 0;
  int n_fail   = 0;

  frog_referee #(.LIVES(3), .FLASH_CYCLES(FC), .SCORE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .red_in    (red_v),
    .green_in  (green_v),
    .red_out   (red_out),
    .green_out (green_out),
    .frog_rst  (frog_rst),
    .freeze    (freeze),
    .lives     (lives),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one edge; inputs/outputs are handled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    red_v   = '0;
    green_v = '0;
  endtask

  // Called in the first flash cycle; ends in the frog_rst cycle.
  task automatic flash(input string tag, input logic is_hit);
    for (int i = 0; i < FC; i++) begin
      check({tag, "_freeze"}, freeze, 1'b1);
      if (is_hit) check({tag, "_red_ones"}, red_out, ONES);
      else        check({tag, "_green_ones"}, green_out, ONES);
      tick();
    end
    check({tag, "_end_freeze"}, freeze, 1'b0);
    check({tag, "_frog_rst"}, frog_rst, 1'b1);
  endtask

  task automatic hit_once(input string tag);
    red_v[3] = 8'h01; green_v[3] = 8'h01;
    tick();
    clear_inputs();
    flash(tag, 1'b1);
    tick();
  endtask

  task automatic goal_once(input string tag);
    green_v[0] = 8'h20;
    tick();
    clear_inputs();
    flash(tag, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; clear_inputs();
    tick(); tick();
    reset = 1'b0;
    // Reset defaults and passthrough
    check("rst_lives", lives, 3'd3);
    check("rst_score", score, 4'd0);
    check("rst_freeze", freeze, 1'b0);
    check("rst_frog_rst", frog_rst, 1'b0);
    check("rst_game_over", game_over, 1'b0);
    red_v[6] = 8'hF0; green_v[7] = 8'h08;
    #1;
    check("pass_red", red_out, 64'h00F0_0000_0000_0000);
    check("pass_green", green_out, 64'h0800_0000_0000_0000);
    tick();
    check("pass_no_hit", freeze, 1'b0);
    clear_inputs();

    // Single hit on row 5
    red_v[5] = 8'h10; green_v[5] = 8'h10;
    tick();
    clear_inputs();
    check("hit_lives", lives, 3'd2);
    check("hit_green_zero", green_out, 64'h0);
    flash("hit1", 1'b1);
    check("hit1_lives", lives, 3'd2);
    // Overlap during the frog_rst cycle is ignored
    red_v[5] = 8'h10; green_v[5] = 8'h10;
    tick();
    clear_inputs();
    check("mask_freeze", freeze, 1'b0);
    check("mask_lives", lives, 3'd2);
    check("mask_frog_rst", frog_rst, 1'b0);

    // Goal
    green_v[0] = 8'h08;
    tick();
    clear_inputs();
    check("goal_score", score, 4'd1);
    check("goal_red_zero", red_out, 64'h0);
    flash("win1", 1'b0);
    tick();

    // Overlap plus goal: collision wins
    red_v[0] = 8'h08; green_v[0] = 8'h08;
    tick();
    clear_inputs();
    check("prio_score", score, 4'd1);
    check("prio_lives", lives, 3'd1);
    flash("hit2", 1'b1);
    tick();

    // Restart ignored in PLAY
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_ign_lives", lives, 3'd1);
    check("restart_ign_frog_rst", frog_rst, 1'b0);
    check("restart_ign_go", game_over, 1'b0);

    // Third collision -> OVER
    red_v[2] = 8'h80; green_v[2] = 8'h80;
    tick();
    clear_inputs();
    check("over_lives", lives, 3'd0);
    for (int i = 0; i < 6; i++) begin
      check("over_hold", game_over, 1'b1);
      tick();
    end
    check("over_red", red_out, ONES);
    check("over_green", green_out, ONES);
    check("over_freeze", freeze, 1'b1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_lives", lives, 3'd3);
    check("restart_score", score, 4'd0);
    check("restart_frog_rst", frog_rst, 1'b1);
    check("restart_go", game_over, 1'b0);
    // Goal during the frog_rst cycle is ignored
    green_v[0] = 8'h01;
    tick();
    clear_inputs();
    check("mask_goal_score", score, 4'd0);
    check("mask_goal_freeze", freeze, 1'b0);

    // Saturation and bonus life
    reset = 1'b1; tick(); reset = 1'b0;
    hit_once("bonus_hit");
    check("bonus_pre_lives", lives, 3'd2);
    for (int g = 1; g <= 20; g++) begin
      goal_once("sat");
      check("sat_score", score, (g > 15) ? 4'd15 : 4'(g));
      if (g == 3) check("bonus_pre4_lives", lives, 3'd2);
      if (g == 4) check("bonus_lives", lives, BONUS_LIVES);
    end
    check("sat_end_lives", lives, BONUS_LIVES);

    // Reset mid-HIT at timer = 2
    red_v[1] = 8'h02; green_v[1] = 8'h02;
    tick();
    clear_inputs();
    tick(); tick();
    check("midhit_freeze_before", freeze, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midhit_freeze", freeze, 1'b0);
    check("midhit_lives", lives, 3'd3);
    check("midhit_score", score, 4'd0);
    check("midhit_frog_rst", frog_rst, 1'b0);
    tick();
    check("midhit_frog_rst_after", frog_rst, 1'b0);
    check("midhit_freeze_after", freeze, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
